// File: rtl/muxn_reg_hs.sv
// muxn_reg_hs: N-channel, W-bit multiplexer with a one-entry registered output
// stage and valid/ready handshakes on both sides.
//
// Channel choice is either an explicit select or, when the MUXN_RR_EN macro is
// defined, a round-robin scan of the valid channels starting at a rotating
// pointer. Without MUXN_RR_EN the mode input is ignored and the pointer logic
// is not built.
//
// The output register accepts a new word whenever it is empty or being drained
// in the same cycle, so a continuously ready consumer sees one word per cycle.

module muxn_reg_hs #(
  parameter int N = 4,
  parameter int W = 8,
  localparam int SW = $clog2(N)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N*W-1:0] in_data,
  input  logic [N-1:0]   in_valid,
  output logic [N-1:0]   in_ready,
  input  logic [SW-1:0]  sel,
  input  logic           mode,
  output logic [W-1:0]   out_data,
  output logic [SW-1:0]  out_ch,
  output logic           out_valid,
  input  logic           out_ready,
  output logic           sel_err
);

  // N widened by one bit so a full-range select can be compared against it.
  localparam logic [SW:0]   N_EXT   = (SW+1)'(N);
  localparam logic [SW-1:0] LAST_CH = SW'(N-1);

  // Output register state.
  logic          out_valid_q, out_valid_d;
  logic [W-1:0]  out_data_q,  out_data_d;
  logic [SW-1:0] out_ch_q,    out_ch_d;
  logic          sel_err_q,   sel_err_d;

  // Channel choice and handshake terms.
  logic          rr_mode;
  logic          sel_ok;
  logic [SW-1:0] choice_ch;
  logic          choice_ok;
  logic          choice_valid;
  logic [W-1:0]  choice_data;
  logic          load_en;
  logic          xfer;

`ifdef MUXN_RR_EN
  logic [SW-1:0] ptr_q, ptr_d;
  assign rr_mode = mode;
`else
  logic unused_mode;
  assign unused_mode = mode;
  assign rr_mode     = 1'b0;
`endif

  // Look up one bit of a channel vector by a run-time channel index.
  function automatic logic valid_at(input logic [N-1:0] v, input logic [SW-1:0] idx);
    valid_at = 1'b0;
    for (int j = 0; j < N; j++) begin
      if (idx == SW'(j)) valid_at = v[j];
    end
  endfunction

  // Look up one W-bit word of the packed channel bus by a run-time index.
  function automatic logic [W-1:0] data_at(input logic [N*W-1:0] d, input logic [SW-1:0] idx);
    data_at = '0;
    for (int j = 0; j < N; j++) begin
      if (idx == SW'(j)) data_at = d[j*W +: W];
    end
  endfunction

  // An explicit select only names a real channel when it is below N.
  assign sel_ok  = ({1'b0, sel} < N_EXT);

  // The single output entry can take a word when empty or draining now.
  assign load_en = !out_valid_q || out_ready;

  // Pick the channel for this cycle: explicit select or round-robin scan.
  always_comb begin
    choice_ch = sel;
    choice_ok = sel_ok;
`ifdef MUXN_RR_EN
    if (rr_mode) begin
      int            scan_k;
      logic [SW-1:0] scan_idx;
      choice_ch = '0;
      choice_ok = 1'b0;
      scan_k    = 0;
      scan_idx  = '0;
      // Walk from farthest to nearest so the channel closest to ptr wins.
      for (int i = N-1; i >= 0; i--) begin
        scan_k = int'(ptr_q) + i;
        if (scan_k >= N) scan_k = scan_k - N;
        scan_idx = SW'(scan_k);
        if (valid_at(in_valid, scan_idx)) begin
          choice_ch = scan_idx;
          choice_ok = 1'b1;
        end
      end
    end
`endif
  end

  assign choice_valid = valid_at(in_valid, choice_ch);
  assign choice_data  = data_at(in_data, choice_ch);
  assign xfer         = !rst && choice_ok && choice_valid && load_en;

  // Grant ready to the chosen channel only; nothing is granted during reset.
  always_comb begin
    in_ready = '0;
    for (int j = 0; j < N; j++) begin
      if (choice_ch == SW'(j)) in_ready[j] = !rst && choice_ok && load_en;
    end
  end

  // Next state of the output register and the select-error flag.
  always_comb begin
    out_valid_d = xfer || (out_valid_q && !out_ready);
    out_data_d  = out_data_q;
    out_ch_d    = out_ch_q;
    if (xfer) begin
      out_data_d = choice_data;
      out_ch_d   = choice_ch;
    end
    sel_err_d = !rr_mode && !sel_ok;
  end

  // Output register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_ch_q    <= '0;
      sel_err_q   <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_ch_q    <= out_ch_d;
      sel_err_q   <= sel_err_d;
    end
  end

`ifdef MUXN_RR_EN
  // Advance the round-robin pointer past the channel just served.
  always_comb begin
    ptr_d = ptr_q;
    if (xfer && rr_mode) begin
      ptr_d = (choice_ch == LAST_CH) ? '0 : choice_ch + SW'(1);
    end
  end

  // Round-robin pointer register.
  always_ff @(posedge clk) begin
    if (rst) ptr_q <= '0;
    else     ptr_q <= ptr_d;
  end
`endif

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_ch    = out_ch_q;
  assign sel_err   = sel_err_q;

endmodule
